program_loader: RTL and testbench

Upstream feeder for the microprocessor core. Accepts a program as a byte stream over a valid/ready handshake, writes it into the `instructions` array that drives the core's instruction memory input, and holds the core in reset (`cpu_rst`, active-low) until loading completes. A new load can be started at any time from run mode; the core is re-held in reset for the whole reload.

---
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Purpose : streams a program into the core's instruction image and holds the core in reset until the load completes.
// Latency : load_start -> CLEAR -> LOAD (in_ready high) -> RUN; cpu_rst releases 2+W cycles after load_start for W gap-free words.
// Backpressure: in_ready is high only in LOAD; the stream stalls before load_start, during CLEAR, and once RUN is reached.
//
// Ports:
//   clk, rst          : clock; asynchronous active-low reset
//   load_start        : single-cycle (re)load request, honoured in IDLE and RUN only
//   in_valid/in_ready : word handshake; in_data is the word, in_last flags the final word
//   instructions      : MEM_SIZE x DATA_WIDTH program image driven to the core
//   cpu_rst           : core reset, active-low (0 = core held)
//   load_done         : program loaded, core running
//   load_error        : memory filled before in_last arrived (program truncated)
//   load_count        : words written in the current or last load
module program_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] instructions [0:MEM_SIZE-1],
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   load_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_instr [0:MEM_SIZE-1];
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_error;
    logic                  w_hs;
    logic                  w_at_end;

    // in_ready is a pure decode of LOAD, so the handshake needs no extra term.
    assign w_hs     = in_valid && (r_state == S_LOAD);
    assign w_at_end = (r_ptr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        cpu_rst      = 1'b0;
        load_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                // Writing the last word always terminates the load, tagged or not,
                // so the pointer can never step past the end of the array.
                if (w_hs && (in_last || w_at_end)) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                cpu_rst   = 1'b1;
                load_done = 1'b1;
                if (load_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                r_instr[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                r_instr[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else if (w_hs) begin
            r_instr[r_ptr] <= in_data;
            r_count        <= r_count + (ADDR_WIDTH + 1)'(1);
            // Pointer holds at the last address; the state machine leaves LOAD there.
            if (!w_at_end) begin
                r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
            if (w_at_end && !in_last) begin
                r_error <= 1'b1;
            end
        end
    end

    assign instructions = r_instr;
    assign load_count   = r_count;
    assign load_error   = r_error;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int MS = 64;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_LOAD  = 2;
    localparam int P_RUN   = 3;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          load_start = 1'b0;
    logic          in_valid   = 1'b0;
    logic [DW-1:0] in_data    = '0;
    logic          in_last    = 1'b0;
    logic          in_ready;
    logic [DW-1:0] instructions [0:MS-1];
    logic          cpu_rst;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   load_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] tx [0:MS-1];

    // Behavioural model: the program image is simply the list of words accepted
    // since the last clear; everything observable is derived from that list.
    int            m_phase = P_IDLE;
    logic [DW-1:0] m_img [$];
    bit            m_err   = 1'b0;

    program_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_SIZE  (MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .instructions(instructions),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .load_error  (load_error),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (idx >= 0) begin
                $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
            end else begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
            end
        end
    endtask

    // Model update on every clock edge and on asynchronous reset.
    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_phase = P_IDLE;
            m_img.delete();
            m_err = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE:  if (load_start) m_phase = P_CLEAR;
                P_CLEAR: begin
                    m_img.delete();
                    m_err   = 1'b0;
                    m_phase = P_LOAD;
                end
                P_LOAD: begin
                    if (in_valid) begin
                        m_img.push_back(in_data);
                        if (in_last) begin
                            m_phase = P_RUN;
                        end else if (m_img.size() == MS) begin
                            m_err   = 1'b1;
                            m_phase = P_RUN;
                        end
                    end
                end
                default: if (load_start) m_phase = P_CLEAR;
            endcase
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always begin
        @(negedge clk);
        chk("in_ready",   -1, int'(in_ready),   int'(m_phase == P_LOAD));
        chk("cpu_rst",    -1, int'(cpu_rst),    int'(m_phase == P_RUN));
        chk("load_done",  -1, int'(load_done),  int'(m_phase == P_RUN));
        chk("load_error", -1, int'(load_error), int'(m_err));
        chk("load_count", -1, int'(load_count), m_img.size());
        for (int i = 0; i < MS; i++) begin
            chk("instructions", i, int'(instructions[i]),
                (i < m_img.size()) ? int'(m_img[i]) : 0);
        end
    end

    // Drives one program from tx[0..n-1]. rel returns the number of clock edges,
    // counted from the edge that samples load_start, until cpu_rst reads high.
    task automatic run_load(input int n, input int gap, input bit set_last, input bit do_start,
                            input int abort_after, input bit poke_start, output int rel);
        int cyc;
        int idx;
        int gapcnt;
        bit hs;
        cyc    = 0;
        idx    = 0;
        gapcnt = 0;
        rel    = -1;
        if (do_start) begin
            @(posedge clk);
            #1 load_start = 1'b1;
            @(posedge clk);
            cyc = 1;
            #1 load_start = 1'b0;
        end
        while (rel < 0 && cyc < 400) begin
            if (idx < n && gapcnt == 0) begin
                in_valid   = 1'b1;
                in_data    = tx[idx];
                in_last    = set_last && (idx == n - 1);
                load_start = 1'b0;
            end else begin
                in_valid   = 1'b0;
                in_data    = 8'($urandom);
                in_last    = 1'($urandom);
                load_start = poke_start && (gapcnt > 0);
            end
            hs = in_valid && in_ready;
            @(posedge clk);
            cyc++;
            #1;
            if (hs) begin
                idx++;
                gapcnt = gap;
            end else if (!in_valid && gapcnt > 0) begin
                gapcnt--;
            end
            if (cpu_rst) rel = cyc;
            if (abort_after >= 0 && idx == abort_after) begin
                in_valid = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("abort_cpu_rst",    -1, int'(cpu_rst),         0);
                chk("abort_in_ready",   -1, int'(in_ready),        0);
                chk("abort_load_count", -1, int'(load_count),      0);
                chk("abort_instr0",     -1, int'(instructions[0]), 0);
                chk("abort_instr1",     -1, int'(instructions[1]), 0);
                @(posedge clk);
                #1 rst = 1'b1;
                break;
            end
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        load_start = 1'b0;
    endtask

    initial begin
        int rel;

        // Reset values while rst is held low.
        #12;
        chk("rst_cpu_rst",    -1, int'(cpu_rst),    0);
        chk("rst_in_ready",   -1, int'(in_ready),   0);
        chk("rst_load_done",  -1, int'(load_done),  0);
        chk("rst_load_count", -1, int'(load_count), 0);
        for (int i = 0; i < MS; i++) chk("rst_instr", i, int'(instructions[i]), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic back-to-back load.
        tx[0] = 8'h81; tx[1] = 8'h42; tx[2] = 8'hC5;
        run_load(3, 0, 1'b1, 1'b1, -1, 1'b0, rel);
        chk("basic_release",    -1, rel, 5);
        chk("basic_instr0",     -1, int'(instructions[0]), 8'h81);
        chk("basic_instr1",     -1, int'(instructions[1]), 8'h42);
        chk("basic_instr2",     -1, int'(instructions[2]), 8'hC5);
        chk("basic_instr3",     -1, int'(instructions[3]), 0);
        chk("basic_load_count", -1, int'(load_count), 3);
        chk("basic_load_error", -1, int'(load_error), 0);

        // Asynchronous reset while running.
        #3 rst = 1'b0;
        #1;
        chk("midrun_cpu_rst",    -1, int'(cpu_rst),         0);
        chk("midrun_load_done",  -1, int'(load_done),       0);
        chk("midrun_load_count", -1, int'(load_count),      0);
        chk("midrun_instr0",     -1, int'(instructions[0]), 0);
        chk("midrun_instr2",     -1, int'(instructions[2]), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Gapped valid with load_start poked during the gaps.
        run_load(3, 2, 1'b1, 1'b1, -1, 1'b1, rel);
        chk("gapped_release",    -1, rel, 9);
        chk("gapped_instr1",     -1, int'(instructions[1]), 8'h42);
        chk("gapped_load_count", -1, int'(load_count), 3);

        // Overflow: 64 words, in_last never set.
        for (int i = 0; i < MS; i++) tx[i] = 8'(i);
        run_load(MS, 0, 1'b0, 1'b1, -1, 1'b0, rel);
        chk("ovf_release",    -1, rel, 66);
        chk("ovf_load_error", -1, int'(load_error), 1);
        chk("ovf_load_count", -1, int'(load_count), 64);
        // A 65th word must not be taken.
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("ovf_in_ready",   -1, int'(in_ready), 0);
        chk("ovf_instr0",     -1, int'(instructions[0]), 8'h00);
        chk("ovf_instr63",    -1, int'(instructions[63]), 8'h3F);
        chk("ovf_count_hold", -1, int'(load_count), 64);

        // Full legal load: in_last on the 64th word.
        for (int i = 0; i < MS; i++) tx[i] = 8'(i) ^ 8'hA5;
        run_load(MS, 0, 1'b1, 1'b1, -1, 1'b0, rel);
        chk("full_release",    -1, rel, 66);
        chk("full_load_error", -1, int'(load_error), 0);
        chk("full_load_count", -1, int'(load_count), 64);
        chk("full_instr63",    -1, int'(instructions[63]), 8'h9A);

        // Reload from RUN: core re-held next cycle, image zeroed after CLEAR.
        @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        chk("reload_cpu_rst",   -1, int'(cpu_rst),   0);
        chk("reload_load_done", -1, int'(load_done), 0);
        @(posedge clk);
        #1;
        chk("reload_in_ready",   -1, int'(in_ready),        1);
        chk("reload_load_count", -1, int'(load_count),      0);
        chk("reload_instr5",     -1, int'(instructions[5]), 0);
        tx[0] = 8'h99;
        run_load(1, 0, 1'b1, 1'b0, -1, 1'b0, rel);
        chk("one_release",    -1, rel, 1);
        chk("one_instr0",     -1, int'(instructions[0]), 8'h99);
        chk("one_instr1",     -1, int'(instructions[1]), 0);
        chk("one_load_count", -1, int'(load_count), 1);

        // Abort: reset after 2 of 5 words.
        for (int i = 0; i < 5; i++) tx[i] = 8'h10 + 8'(i);
        run_load(5, 0, 1'b1, 1'b1, 2, 1'b0, rel);
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_cpu_rst", -1, int'(cpu_rst),  0);
        chk("post_abort_ready",   -1, int'(in_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
